// File: rtl/flash_sequencer.sv
// flash_sequencer: frame-based text-flash and cursor-blink phase generator.
// Three-state FSM (IDLE/ON/OFF) counts frameTick pulses against active
// period registers that are copied from the writable config registers only
// at phase boundaries, so a write never stretches or shortens a running phase.
// Handshake: none. cfgWr is a one-cycle strobe that is accepted unconditionally
// on the edge that samples it, and frameTick is a one-cycle event with no back-pressure.
module flash_sequencer #(
  parameter logic [7:0] DEFAULT_ON  = 8'd30,
  parameter logic [7:0] DEFAULT_OFF = 8'd30,
  parameter logic [7:0] DEFAULT_CUR = 8'd15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       frameTick,
  input  logic       cfgWr,
  input  logic [1:0] cfgAddr,
  input  logic [7:0] cfgData,
  output logic       flashClk,
  output logic       cursorOn,
  output logic       phaseEdge,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cur_cnt_q, cur_cnt_d;
  logic [7:0] act_on_q, act_on_d;
  logic [7:0] act_off_q, act_off_d;
  logic [7:0] act_cur_q, act_cur_d;
  logic [7:0] cfg_on_q, cfg_on_d;
  logic [7:0] cfg_off_q, cfg_off_d;
  logic [7:0] cfg_cur_q, cfg_cur_d;
  logic       force_on_q, force_on_d;
  logic       flash_clk_q, flash_clk_d;
  logic       cursor_on_q, cursor_on_d;
  logic       phase_edge_q, phase_edge_d;

  logic       restart;
  logic [8:0] cnt_inc;
  logic [8:0] cur_inc;
  logic [7:0] phase_len;

  // A zero period means a one-frame phase.
  function automatic logic [7:0] nz(input logic [7:0] v);
    return (v == 8'd0) ? 8'd1 : v;
  endfunction

  // Next-state, counter, config and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cur_cnt_d    = cur_cnt_q;
    act_on_d     = act_on_q;
    act_off_d    = act_off_q;
    act_cur_d    = act_cur_q;
    cfg_on_d     = cfg_on_q;
    cfg_off_d    = cfg_off_q;
    cfg_cur_d    = cfg_cur_q;
    force_on_d   = force_on_q;
    cursor_on_d  = cursor_on_q;
    phase_edge_d = 1'b0;

    restart   = cfgWr && (cfgAddr == 2'd3) && cfgData[1];
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    cur_inc   = {1'b0, cur_cnt_q} + 9'd1;
    phase_len = (state_q == S_OFF) ? act_off_q : act_on_q;

    // Config registers update right away; the active copies below still
    // read the old (_q) values, so a write on a transition edge is not used
    // for the phase that starts on that edge. Restart bit is never stored.
    if (cfgWr) begin
      case (cfgAddr)
        2'd0:    cfg_on_d   = cfgData;
        2'd1:    cfg_off_d  = cfgData;
        2'd2:    cfg_cur_d  = cfgData;
        default: force_on_d = cfgData[0];
      endcase
    end

    if (!enable) begin
      state_d     = S_IDLE;
      cnt_d       = 8'd0;
      cur_cnt_d   = 8'd0;
      cursor_on_d = 1'b0;
    end else if ((state_q == S_IDLE) || restart) begin
      // Fresh entry (or restart): phase edge only if the text was hidden.
      state_d      = S_ON;
      cnt_d        = 8'd0;
      cur_cnt_d    = 8'd0;
      cursor_on_d  = 1'b1;
      act_on_d     = nz(cfg_on_q);
      act_off_d    = nz(cfg_off_q);
      act_cur_d    = nz(cfg_cur_q);
      phase_edge_d = (state_q == S_OFF);
    end else if (frameTick) begin
      // >= rather than == keeps the counters from ever wrapping.
      if (cnt_inc >= {1'b0, phase_len}) begin
        state_d      = (state_q == S_ON) ? S_OFF : S_ON;
        cnt_d        = 8'd0;
        act_on_d     = nz(cfg_on_q);
        act_off_d    = nz(cfg_off_q);
        act_cur_d    = nz(cfg_cur_q);
        phase_edge_d = 1'b1;
      end else begin
        cnt_d = cnt_inc[7:0];
      end
      if (cur_inc >= {1'b0, act_cur_q}) begin
        cursor_on_d = ~cursor_on_q;
        cur_cnt_d   = 8'd0;
      end else begin
        cur_cnt_d = cur_inc[7:0];
      end
    end

    flash_clk_d = (state_d == S_ON) || (force_on_d && enable);
  end

  // All state and registered outputs; reset discards any phase progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 8'd0;
      cur_cnt_q    <= 8'd0;
      act_on_q     <= nz(DEFAULT_ON);
      act_off_q    <= nz(DEFAULT_OFF);
      act_cur_q    <= nz(DEFAULT_CUR);
      cfg_on_q     <= DEFAULT_ON;
      cfg_off_q    <= DEFAULT_OFF;
      cfg_cur_q    <= DEFAULT_CUR;
      force_on_q   <= 1'b0;
      flash_clk_q  <= 1'b0;
      cursor_on_q  <= 1'b0;
      phase_edge_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_cnt_q    <= cur_cnt_d;
      act_on_q     <= act_on_d;
      act_off_q    <= act_off_d;
      act_cur_q    <= act_cur_d;
      cfg_on_q     <= cfg_on_d;
      cfg_off_q    <= cfg_off_d;
      cfg_cur_q    <= cfg_cur_d;
      force_on_q   <= force_on_d;
      flash_clk_q  <= flash_clk_d;
      cursor_on_q  <= cursor_on_d;
      phase_edge_q <= phase_edge_d;
    end
  end

  assign flashClk  = flash_clk_q;
  assign cursorOn  = cursor_on_q;
  assign phaseEdge = phase_edge_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_sequencer.sv
// tb_flash_sequencer: directed scenarios plus random traffic for flash_sequencer.
module tb_flash_sequencer;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       frameTick;
  logic       cfgWr;
  logic [1:0] cfgAddr;
  logic [7:0] cfgData;
  logic       flashClk;
  logic       cursorOn;
  logic       phaseEdge;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  flash_sequencer dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .frameTick (frameTick),
    .cfgWr     (cfgWr),
    .cfgAddr   (cfgAddr),
    .cfgData   (cfgData),
    .flashClk  (flashClk),
    .cursorOn  (cursorOn),
    .phaseEdge (phaseEdge),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];
  string scen = "init";

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h exp=%0h t=%0t", scen, tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Text phase tracked as frames remaining; cursor as frames elapsed.
  bit m_run, m_vis, m_cur_vis, m_force;
  int m_left, m_cur_el;
  int m_cfg[3];
  int m_len[3];

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_vis = 0; m_cur_vis = 0; m_force = 0;
    m_left = 0; m_cur_el = 0;
    m_cfg[0] = 30; m_cfg[1] = 30; m_cfg[2] = 15;
    m_len[0] = 30; m_len[1] = 30; m_len[2] = 15;
  endtask

  task automatic model_step(input bit en, input bit tick, input bit wr,
                            input logic [1:0] addr, input logic [7:0] data,
                            output logic [2:0] e);
    int old[3];
    bit restart;
    bit edge_p;
    old = m_cfg;
    restart = wr && (addr == 2'd3) && data[1];
    edge_p = 0;
    if (wr) begin
      case (addr)
        2'd0: m_cfg[0] = int'(data);
        2'd1: m_cfg[1] = int'(data);
        2'd2: m_cfg[2] = int'(data);
        default: m_force = data[0];
      endcase
    end
    if (!en) begin
      m_run = 0; m_vis = 0; m_cur_vis = 0;
    end else if (!m_run || restart) begin
      edge_p = m_run && !m_vis;
      m_run = 1; m_vis = 1; m_cur_vis = 1;
      for (int i = 0; i < 3; i++) m_len[i] = nz(old[i]);
      m_left = m_len[0];
      m_cur_el = 0;
    end else if (tick) begin
      m_cur_el++;
      if (m_cur_el >= m_len[2]) begin
        m_cur_vis = !m_cur_vis;
        m_cur_el = 0;
      end
      m_left--;
      if (m_left == 0) begin
        m_vis = !m_vis;
        edge_p = 1;
        for (int i = 0; i < 3; i++) m_len[i] = nz(old[i]);
        m_left = m_vis ? m_len[0] : m_len[1];
      end
    end
    e = {m_vis || (m_force && en), m_cur_vis, edge_p};
  endtask

  // ---------------- driver tasks ----------------
  bit cur_en = 0;
  int edge_cnt;
  int cur_toggles;
  logic prev_cur;

  task automatic step(input bit en, input bit tick, input bit wr,
                      input logic [1:0] addr, input logic [7:0] data);
    logic [2:0] e;
    logic [2:0] got;
    enable = en; frameTick = tick; cfgWr = wr; cfgAddr = addr; cfgData = data;
    @(posedge clock);
    model_step(en, tick, wr, addr, data, e);
    exp_q.push_back(e);
    #1;
    got = exp_q.pop_front();
    check_val("flashClk", 32'(flashClk), 32'(got[2]));
    check_val("cursorOn", 32'(cursorOn), 32'(got[1]));
    check_val("phaseEdge", 32'(phaseEdge), 32'(got[0]));
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(cur_en, 0, 0, 2'd0, 8'd0);
  endtask

  task automatic tick_frame();
    step(cur_en, 1, 0, 2'd0, 8'd0);
    edge_cnt += int'(phaseEdge);
    if (cursorOn !== prev_cur) cur_toggles++;
    prev_cur = cursorOn;
    gap(1);
  endtask

  task automatic cfg_write(input logic [1:0] addr, input logic [7:0] data);
    step(cur_en, 0, 1, addr, data);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0; frameTick = 1'b0; cfgWr = 1'b0; cfgAddr = 2'd0; cfgData = 8'd0;
    cur_en = 0;
    #1;
    check_val("rst.flashClk", 32'(flashClk), 32'd0);
    check_val("rst.cursorOn", 32'(cursorOn), 32'd0);
    check_val("rst.phaseEdge", 32'(phaseEdge), 32'd0);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic start_enabled();
    cur_en = 1;
    step(1, 0, 0, 2'd0, 8'd0);
    edge_cnt = 0;
    cur_toggles = 0;
    prev_cur = cursorOn;
  endtask

  // ---------------- stimulus ----------------
  logic fr[0:130];

  initial begin
    reset = 1'b0;
    enable = 1'b0; frameTick = 1'b0; cfgWr = 1'b0; cfgAddr = 2'd0; cfgData = 8'd0;
    model_reset();
    #12;

    // Default timing: 30/30 text, 15-frame cursor.
    scen = "defaults";
    do_reset();
    gap(2);
    start_enabled();
    for (int k = 0; k < 130; k++) begin
      check_val("frame", 32'(flashClk), 32'((k % 60) < 30));
      tick_frame();
    end
    check_val("edge_count", 32'(edge_cnt), 32'd4);
    check_val("cursor_toggles", 32'(cur_toggles), 32'd8);

    // onFrames=0 (one frame), offFrames=2, restart.
    scen = "zero_on";
    cfg_write(2'd0, 8'd0);
    cfg_write(2'd1, 8'd2);
    cfg_write(2'd3, 8'd2);
    for (int k = 0; k < 6; k++) begin
      fr[k] = flashClk;
      tick_frame();
    end
    check_val("pattern", 32'({fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]}), 32'b100100);

    // Mid-ON period write only affects the following ON phase.
    scen = "mid_on_write";
    do_reset();
    start_enabled();
    for (int k = 0; k < 70; k++) begin
      if (k == 10) cfg_write(2'd0, 8'd5);
      fr[k] = flashClk;
      tick_frame();
    end
    check_val("f29", 32'(fr[29]), 32'd1);
    check_val("f30", 32'(fr[30]), 32'd0);
    check_val("f59", 32'(fr[59]), 32'd0);
    check_val("f64", 32'(fr[64]), 32'd1);
    check_val("f65", 32'(fr[65]), 32'd0);

    // Restart coincident with the phase-completing tick.
    scen = "restart_tick";
    do_reset();
    start_enabled();
    for (int k = 0; k < 29; k++) tick_frame();
    step(1, 1, 1, 2'd3, 8'd2);
    check_val("still_on", 32'(flashClk), 32'd1);
    check_val("no_edge", 32'(phaseEdge), 32'd0);
    gap(1);
    for (int k = 0; k < 31; k++) begin
      fr[k] = flashClk;
      tick_frame();
    end
    check_val("f29", 32'(fr[29]), 32'd1);
    check_val("f30", 32'(fr[30]), 32'd0);

    // forceOn during OFF, then enable dropped mid-phase.
    scen = "force_on";
    do_reset();
    start_enabled();
    for (int k = 0; k < 30; k++) tick_frame();
    cfg_write(2'd3, 8'd1);
    check_val("forced", 32'(flashClk), 32'd1);
    edge_cnt = 0;
    for (int k = 0; k < 60; k++) begin
      check_val("forced_frame", 32'(flashClk), 32'd1);
      tick_frame();
    end
    check_val("edge_count", 32'(edge_cnt), 32'd2);
    for (int k = 0; k < 7; k++) tick_frame();
    cur_en = 0;
    step(0, 1, 0, 2'd0, 8'd0);
    check_val("dis_flash", 32'(flashClk), 32'd0);
    check_val("dis_cursor", 32'(cursorOn), 32'd0);
    check_val("dis_edge", 32'(phaseEdge), 32'd0);
    gap(2);

    // Reset mid-OFF with non-default config restores 30/30/15.
    scen = "reset_mid_off";
    start_enabled();
    cfg_write(2'd0, 8'd3);
    cfg_write(2'd1, 8'd4);
    cfg_write(2'd2, 8'd2);
    cfg_write(2'd3, 8'd2);
    for (int k = 0; k < 5; k++) tick_frame();
    check_val("in_off", 32'(flashClk), 32'd0);
    do_reset();
    start_enabled();
    for (int k = 0; k < 65; k++) begin
      check_val("frame", 32'(flashClk), 32'((k % 60) < 30));
      tick_frame();
    end
    check_val("cursor_toggles", 32'(cur_toggles), 32'd4);

    // Random traffic against the model.
    scen = "random";
    do_reset();
    cur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      bit en, tk, wr;
      logic [1:0] a;
      logic [7:0] d;
      en = ($urandom_range(0, 39) != 0);
      tk = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 7) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = (a == 2'd3) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 4));
      if ($urandom_range(0, 499) == 0) do_reset();
      step(en, tk, wr, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_sequencer.md
FLASH_SEQUENCER -- requirements
Module: flash_sequencer

Interface
REQ-001 Parameter DEFAULT_ON, default 8'd30: text-flash on-phase length in frames after reset.
REQ-002 Parameter DEFAULT_OFF, default 8'd30: text-flash off-phase length in frames after reset.
REQ-003 Parameter DEFAULT_CUR, default 8'd15: cursor half-period in frames after reset.
REQ-004 clock  input  1  single system clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 enable  input  1  level; 1 = flash sequencing active.
REQ-007 frameTick  input  1  one-cycle pulse per frame (vsync start).
REQ-008 cfgWr  input  1  one-cycle config write strobe.
REQ-009 cfgAddr  input  2  0=onFrames, 1=offFrames, 2=curFrames, 3=control.
REQ-010 cfgData  input  8  write data; control: bit0 forceOn, bit1 restart.
REQ-011 flashClk  output  1  registered text-flash phase, 1 = visible.
REQ-012 cursorOn  output  1  registered cursor-visible phase.
REQ-013 phaseEdge  output  1  registered one-cycle pulse on every flashClk change caused by the FSM.

Function
REQ-014 The FSM SHALL have states IDLE, ON, OFF; flashClk = 1 only in ON, or whenever forceOn = 1 and enable = 1.
REQ-015 In IDLE with enable = 1, the next edge SHALL enter ON with frame counter = 0, load the active periods from the config registers, and set cursorOn = 1.
REQ-016 In ON, each frameTick SHALL increment the frame counter; the frameTick at which counter+1 == active onFrames SHALL move to OFF, clear the counter, and pulse phaseEdge.
REQ-017 In OFF, the same rule with active offFrames SHALL move to ON.
REQ-018 The state change and the flashClk/phaseEdge update SHALL occur on the same edge that samples frameTick (outputs visible one cycle after the tick).
REQ-019 A config register value of 0 SHALL be treated as 1 (one-frame phase).
REQ-020 Period writes SHALL update the config registers immediately but SHALL take effect only at the next ON/OFF transition or at IDLE-to-ON entry; the current phase length is unchanged.
REQ-021 The frame counter SHALL be 8 bits and SHALL never wrap: it is cleared at every transition before reaching 255.
REQ-022 In ON/OFF, enable = 0 SHALL force IDLE on the next edge: flashClk = 0, cursorOn = 0, counters cleared, no phaseEdge.
REQ-023 Writing control with bit1 = 1 (restart) SHALL behave like IDLE-to-ON entry on the next edge; bit1 is self-clearing and reads as 0.
REQ-024 Restart coincident with a frameTick that would complete a phase SHALL win: the state is ON with counter = 0, and phaseEdge pulses only if flashClk changes.
REQ-025 forceOn SHALL mask flashClk to 1 without stopping the FSM; phaseEdge SHALL still reflect the internal phase changes.
REQ-026 Cursor: while enable = 1, a separate 8-bit counter SHALL toggle cursorOn on every active-curFrames-th frameTick, independent of the text phase.
REQ-027 Simultaneous cfgWr and frameTick SHALL process both; a period write on the transition edge SHALL NOT be used for the phase starting on that edge.

Reset
REQ-028 Asserted reset SHALL immediately force: state IDLE; flashClk = 0, cursorOn = 0, phaseEdge = 0; counters = 0; config registers = DEFAULT_ON, DEFAULT_OFF, DEFAULT_CUR; forceOn = 0.
REQ-029 Reset asserted mid-phase SHALL discard all progress; after release the block SHALL behave as if freshly enabled.

Verification
REQ-030 Defaults, enable = 1, 130 frameTicks -> flashClk 1 for frames 0-29, 0 for frames 30-59, repeating; phaseEdge exactly 4 pulses; cursorOn toggles every 15 ticks.
REQ-031 Write onFrames = 0, offFrames = 2, then restart -> flashClk pattern 1,0,0,1,0,0 per frame.
REQ-032 Mid-ON (tick 10 of 30), write onFrames = 5 -> current ON lasts 30 ticks; the following ON lasts 5.
REQ-033 Restart on the same cycle as the 30th ON tick -> stays ON, counter = 0, no phaseEdge; next OFF after 30 further ticks.
REQ-034 forceOn = 1 during OFF -> flashClk = 1 while phaseEdge keeps pulsing at 30-frame intervals; enable low mid-phase -> all outputs 0 next edge.
REQ-035 Assert reset mid-OFF with non-default config -> outputs 0 immediately; after release and enable, 30/30/15 timing restored.
